// File: rtl/lb_awg_regfile_pkg.sv
// Shared definitions for the AWG local-bus register file: offsets, bit indices, FSM encoding.
package lb_awg_regfile_pkg;

  localparam logic [4:0] OFS_CTRL    = 5'h00;
  localparam logic [4:0] OFS_LENGTH  = 5'h04;
  localparam logic [4:0] OFS_STATUS  = 5'h08;
  localparam logic [4:0] OFS_SCRATCH = 5'h0C;
  localparam logic [4:0] OFS_VERSION = 5'h10;
  localparam logic [4:0] OFS_ERRCNT  = 5'h14;

  localparam int CTRL_RUN_BIT      = 0;
  localparam int CTRL_LOOP_BIT     = 1;
  localparam int CTRL_TRIG_BIT     = 4;
  localparam int STAT_BUSY_BIT     = 0;
  localparam int STAT_UNDERRUN_BIT = 1;

  localparam logic [31:0] UNMAPPED_RDAT = 32'hDEAD_BEEF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RWAIT = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_LENGTH  = 3'd1,
    REG_STATUS  = 3'd2,
    REG_SCRATCH = 3'd3,
    REG_VERSION = 3'd4,
    REG_ERRCNT  = 3'd5,
    REG_NONE    = 3'd7
  } reg_idx_t;

endpackage

// File: rtl/lb_addr_decode.sv
// Combinational address classifier: register index, RAM-window hit, or unmapped.
// 0x14 only decodes as ERRCNT when LB_ERR_CNT_EN is defined.
module lb_addr_decode
  import lb_awg_regfile_pkg::*;
#(
  parameter int unsigned RAM_AW   = 10,
  parameter logic [31:0] RAM_BASE = 32'h0000_1000
) (
  input  logic [31:2] adr,
  output reg_idx_t    idx,
  output logic        ram_hit,
  output logic        unmapped
);

  always_comb begin
    idx      = REG_NONE;
    ram_hit  = (adr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);
    unmapped = 1'b0;
    if (!ram_hit && (adr[31:5] == '0)) begin
      case ({adr[4:2], 2'b00})
        OFS_CTRL:    idx = REG_CTRL;
        OFS_LENGTH:  idx = REG_LENGTH;
        OFS_STATUS:  idx = REG_STATUS;
        OFS_SCRATCH: idx = REG_SCRATCH;
        OFS_VERSION: idx = REG_VERSION;
        OFS_ERRCNT: begin
`ifdef LB_ERR_CNT_EN
          idx = REG_ERRCNT;
`else
          idx = REG_NONE;
`endif
        end
        default:     idx = REG_NONE;
      endcase
    end
    unmapped = !ram_hit && (idx == REG_NONE);
  end

endmodule

// File: rtl/lb_awg_regfile.sv
// AWG local-bus slave: register ack 2 cycles after REQ, RAM read RAM_RD_LAT+2; one ack per held request.
// Optional LB_ERR_CNT_EN adds a saturating unmapped-access counter at 0x14.
module lb_awg_regfile
  import lb_awg_regfile_pkg::*;
#(
  parameter int unsigned RAM_AW     = 10,
  parameter int unsigned RAM_RD_LAT = 2,
  parameter logic [31:0] RAM_BASE   = 32'h0000_1000,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic              S_AXI_ACLK,
  input  logic              IP_RST,
  input  logic              IP_LB_WREQ,
  input  logic [31:0]       IP_LB_WADR,
  input  logic [3:0]        IP_LB_WBEN,
  input  logic [31:0]       IP_LB_WDAT,
  output logic              OP_LB_WACK,
  input  logic              IP_LB_RREQ,
  input  logic [31:0]       IP_LB_RADR,
  output logic [31:0]       OP_LB_RDAT,
  output logic              OP_LB_RACK,
  output logic              OP_WAV_WE,
  output logic              OP_WAV_RE,
  output logic [RAM_AW-1:0] OP_WAV_ADR,
  output logic [3:0]        OP_WAV_BEN,
  output logic [31:0]       OP_WAV_WDAT,
  input  logic [31:0]       IP_WAV_RDAT,
  output logic              OP_CTRL_RUN,
  output logic              OP_CTRL_LOOP,
  output logic              OP_SOFT_TRIG,
  output logic [15:0]       OP_WAV_LEN,
  input  logic              IP_AWG_BUSY,
  input  logic              IP_AWG_UNDERRUN
);

  logic [1:0]  state;
  logic        is_wr;
  logic [2:0]  lat_cnt;
  logic [31:0] rdat;
  logic        run;
  logic        loop;
  logic        soft_trig;
  logic        underrun;
  logic [15:0] wav_len;
  logic [31:0] scratch;
  logic [31:0] reg_rdat;

  logic [31:0] acc_adr;
  logic [1:0]  unused_adr_lsb;
  reg_idx_t    idx;
  logic        ram_hit;
  logic        unmapped;
  logic        idle;
  logic        do_wr;
  logic        do_rd;
  logic        wr_ctrl;
  logic        wr_len;
  logic        wr_status;
  logic        wr_scratch;
  logic        underrun_clr;

  assign idle     = (state == ST_IDLE) && !IP_RST;
  assign do_wr    = idle && IP_LB_WREQ;
  assign do_rd    = idle && !IP_LB_WREQ && IP_LB_RREQ;
  // Writes win arbitration, so the decoder looks at the write address whenever WREQ is up.
  assign acc_adr  = IP_LB_WREQ ? IP_LB_WADR : IP_LB_RADR;
  assign unused_adr_lsb = acc_adr[1:0];

  lb_addr_decode #(
    .RAM_AW   (RAM_AW),
    .RAM_BASE (RAM_BASE)
  ) u_decode (
    .adr      (acc_adr[31:2]),
    .idx      (idx),
    .ram_hit  (ram_hit),
    .unmapped (unmapped)
  );

  assign wr_ctrl      = do_wr && (idx == REG_CTRL);
  assign wr_len       = do_wr && (idx == REG_LENGTH);
  assign wr_status    = do_wr && (idx == REG_STATUS);
  assign wr_scratch   = do_wr && (idx == REG_SCRATCH);
  assign underrun_clr = wr_status && IP_LB_WBEN[0] && IP_LB_WDAT[STAT_UNDERRUN_BIT];

`ifdef LB_ERR_CNT_EN
  logic [15:0] errcnt;

  always_ff @(posedge S_AXI_ACLK) begin
    if (IP_RST) begin
      errcnt <= '0;
    end else if (do_wr && (idx == REG_ERRCNT)) begin
      errcnt <= '0;
    end else if ((do_wr || do_rd) && unmapped && (errcnt != 16'hFFFF)) begin
      errcnt <= errcnt + 16'd1;
    end
  end
`endif

  always_comb begin
    reg_rdat = '0;
    case (idx)
      REG_CTRL: begin
        reg_rdat[CTRL_RUN_BIT]  = run;
        reg_rdat[CTRL_LOOP_BIT] = loop;
      end
      REG_LENGTH:  reg_rdat[15:0] = wav_len;
      REG_STATUS: begin
        reg_rdat[STAT_BUSY_BIT]     = IP_AWG_BUSY;
        reg_rdat[STAT_UNDERRUN_BIT] = underrun;
      end
      REG_SCRATCH: reg_rdat = scratch;
      REG_VERSION: reg_rdat = VERSION;
`ifdef LB_ERR_CNT_EN
      REG_ERRCNT:  reg_rdat[15:0] = errcnt;
`endif
      default:     reg_rdat = UNMAPPED_RDAT;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (IP_RST) begin
      run       <= 1'b0;
      loop      <= 1'b0;
      soft_trig <= 1'b0;
      underrun  <= 1'b0;
      wav_len   <= 16'h0001;
      scratch   <= '0;
    end else begin
      soft_trig <= 1'b0;
      if (wr_ctrl && IP_LB_WBEN[0]) begin
        run       <= IP_LB_WDAT[CTRL_RUN_BIT];
        loop      <= IP_LB_WDAT[CTRL_LOOP_BIT];
        soft_trig <= IP_LB_WDAT[CTRL_TRIG_BIT];
      end
      for (int b = 0; b < 2; b++) begin
        if (wr_len && IP_LB_WBEN[b]) wav_len[8*b +: 8] <= IP_LB_WDAT[8*b +: 8];
      end
      for (int b = 0; b < 4; b++) begin
        if (wr_scratch && IP_LB_WBEN[b]) scratch[8*b +: 8] <= IP_LB_WDAT[8*b +: 8];
      end
      // A new underrun event outranks a clear landing in the same cycle.
      underrun <= IP_AWG_UNDERRUN || (underrun && !underrun_clr);
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (IP_RST) begin
      state   <= ST_IDLE;
      is_wr   <= 1'b0;
      lat_cnt <= '0;
      rdat    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (do_wr) begin
            is_wr <= 1'b1;
            state <= ST_ACK;
          end else if (do_rd) begin
            is_wr <= 1'b0;
            if (ram_hit) begin
              lat_cnt <= 3'd1;
              state   <= ST_RWAIT;
            end else begin
              rdat  <= reg_rdat;
              state <= ST_ACK;
            end
          end
        end
        ST_RWAIT: begin
          if (lat_cnt == 3'(RAM_RD_LAT)) begin
            rdat  <= IP_WAV_RDAT;
            state <= ST_ACK;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        ST_ACK: state <= ST_DONE;
        default: begin
          // The bridge drops REQ a cycle after the ack; waiting here stops a second ack.
          if (is_wr ? !IP_LB_WREQ : !IP_LB_RREQ) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign OP_LB_WACK   = (state == ST_ACK) && is_wr && !IP_RST;
  assign OP_LB_RACK   = (state == ST_ACK) && !is_wr && !IP_RST;
  assign OP_LB_RDAT   = rdat;

  assign OP_WAV_WE    = do_wr && ram_hit;
  assign OP_WAV_RE    = do_rd && ram_hit;
  assign OP_WAV_ADR   = idle ? acc_adr[RAM_AW+1:2] : '0;
  assign OP_WAV_BEN   = do_wr ? IP_LB_WBEN : 4'b0000;
  assign OP_WAV_WDAT  = do_wr ? IP_LB_WDAT : 32'h0;

  assign OP_CTRL_RUN  = run;
  assign OP_CTRL_LOOP = loop;
  assign OP_SOFT_TRIG = soft_trig;
  assign OP_WAV_LEN   = wav_len;

endmodule
